// File: rtl/bec_bridge_pkg.sv
// Shared constants for the LA-to-BEC operand bridge:
// opcodes, FSM state encodings and command address fields.
package bec_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b11,
    S_READ = 2'b10
  } state_e;

  localparam logic [7:0] OP_OPEN    = 8'h30;
  localparam logic [7:0] OP_WRITE   = 8'h31;
  localparam logic [7:0] OP_START   = 8'h41;
  localparam logic [7:0] OP_READ    = 8'h10;
  localparam logic [7:0] OP_RELEASE = 8'h20;
  localparam logic [7:0] OP_ABORT   = 8'h7F;

  localparam int ADDR_REG_LSB = 4;
  localparam int ADDR_REG_W   = 4;
  localparam int ADDR_CH_LSB  = 0;
  localparam int ADDR_CH_W    = 4;

  function automatic int num_chunks(input int op_w, input int chunk_w);
    return (op_w + chunk_w - 1) / chunk_w;
  endfunction

endpackage

// File: rtl/la_cmd_sync.sv
// Toggle-handshake front end: 2-flop synchroniser, edge detect,
// command field latch and ack toggle for the operand bridge.
module la_cmd_sync #(
  parameter int CHUNK_W = 82
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_tog,
  input  logic [7:0]         cmd_op,
  input  logic [7:0]         cmd_addr,
  input  logic [CHUNK_W-1:0] cmd_data,
  output logic               exec,
  output logic [7:0]         ex_op,
  output logic [7:0]         ex_addr,
  output logic [CHUNK_W-1:0] ex_data,
  output logic               sts_ack
);

  logic               tog_s1_q, tog_s1_d;
  logic               tog_s2_q, tog_s2_d;
  logic               tog_s3_q, tog_s3_d;
  logic               pend_q, pend_d;
  logic [7:0]         op_q, op_d;
  logic [7:0]         addr_q, addr_d;
  logic [CHUNK_W-1:0] data_q, data_d;
  logic               ack_q, ack_d;
  logic               edge_det;

  assign edge_det = tog_s2_q ^ tog_s3_q;

  always_comb begin
    tog_s1_d = cmd_tog;
    tog_s2_d = tog_s1_q;
    tog_s3_d = tog_s2_q;
    pend_d   = edge_det;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (edge_det) begin
      op_d   = cmd_op;
      addr_d = cmd_addr;
      data_d = cmd_data;
    end
    // ack follows the synced toggle in the execute cycle
    ack_d = pend_q ? tog_s3_q : ack_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tog_s1_q <= 1'b0;
      tog_s2_q <= 1'b0;
      tog_s3_q <= 1'b0;
      pend_q   <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ack_q    <= 1'b0;
    end else begin
      tog_s1_q <= tog_s1_d;
      tog_s2_q <= tog_s2_d;
      tog_s3_q <= tog_s3_d;
      pend_q   <= pend_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
    end
  end

  assign exec    = pend_q;
  assign ex_op   = op_q;
  assign ex_addr = addr_q;
  assign ex_data = data_q;
  assign sts_ack = ack_q;

endmodule

// File: rtl/la_operand_bridge.sv
// LA-to-BEC coprocessor bridge: command FSM, operand/result files,
// key shifter and read mux. BRIDGE_WDOG_EN adds a RUN watchdog.
module la_operand_bridge
  import bec_bridge_pkg::*;
#(
  parameter int OP_W    = 163,
  parameter int CHUNK_W = 82,
  parameter int N_IN    = 7,
  parameter int N_OUT   = 2,
  parameter int KEY_IDX = 6
`ifdef BRIDGE_WDOG_EN
  ,
  parameter int unsigned TIMEOUT = 65535
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_tog,
  input  logic [7:0]            cmd_op,
  input  logic [7:0]            cmd_addr,
  input  logic [CHUNK_W-1:0]    cmd_data,
  output logic                  sts_ack,
  output logic [1:0]            sts_state,
  output logic                  sts_err,
  output logic                  sts_wdog,
  output logic [CHUNK_W-1:0]    rdata,
  output logic                  core_en,
  output logic [N_IN*OP_W-1:0]  core_ops,
  output logic                  core_ki,
  input  logic                  core_next_key,
  input  logic                  core_done,
  input  logic [N_OUT*OP_W-1:0] core_res
);

  localparam int NCH   = num_chunks(OP_W, CHUNK_W);
  localparam int PAD_W = NCH * CHUNK_W;

  logic               exec;
  logic [7:0]         ex_op;
  logic [7:0]         ex_addr;
  logic [CHUNK_W-1:0] ex_data;

  la_cmd_sync #(.CHUNK_W(CHUNK_W)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .cmd_tog  (cmd_tog),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .exec     (exec),
    .ex_op    (ex_op),
    .ex_addr  (ex_addr),
    .ex_data  (ex_data),
    .sts_ack  (sts_ack)
  );

  state_e             state_q, state_d;
  logic [OP_W-1:0]    ops_q [N_IN];
  logic [OP_W-1:0]    ops_d [N_IN];
  logic [OP_W-1:0]    res_q [N_OUT];
  logic [OP_W-1:0]    res_d [N_OUT];
  logic [OP_W-1:0]    res_in [N_OUT];
  logic [CHUNK_W-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               clr;
  logic [OP_W-1:0]    rsel;
  logic [OP_W-1:0]    wmask;
  logic [OP_W-1:0]    wbits;
  logic [3:0]         reg_idx;
  logic [3:0]         ch_idx;
  logic [31:0]        sh;
  logic               in_ok;
  logic               out_ok;
  logic               ch_ok;

  assign reg_idx = ex_addr[ADDR_REG_LSB +: ADDR_REG_W];
  assign ch_idx  = ex_addr[ADDR_CH_LSB +: ADDR_CH_W];
  assign sh      = 32'(ch_idx) * 32'(CHUNK_W);
  assign in_ok   = int'(reg_idx) < N_IN;
  assign out_ok  = int'(reg_idx) < N_OUT;
  assign ch_ok   = int'(ch_idx) < NCH;
  // bits shifted past OP_W fall off the top of the last chunk
  assign wmask   = OP_W'(PAD_W'({CHUNK_W{1'b1}}) << sh);
  assign wbits   = OP_W'(PAD_W'(ex_data) << sh);

  for (genvar g = 0; g < N_IN; g++) begin : g_ops
    assign core_ops[g*OP_W +: OP_W] = ops_q[g];
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_res
    assign res_in[g] = core_res[g*OP_W +: OP_W];
  end

  always_comb begin
    rsel = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (int'(reg_idx) == i) rsel = res_q[i];
    end
  end

`ifdef BRIDGE_WDOG_EN
  logic [31:0] cnt_q, cnt_d;
  logic        wdog_q, wdog_d;
`endif

  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    res_d   = res_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    clr     = 1'b0;
`ifdef BRIDGE_WDOG_EN
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
`endif

    if (state_q == S_RUN) begin
      if (core_next_key) ops_d[KEY_IDX] = ops_q[KEY_IDX] >> 1;
      if (core_done) begin
        res_d   = res_in;
        state_d = S_READ;
      end
`ifdef BRIDGE_WDOG_EN
      else if (cnt_q == TIMEOUT) begin
        wdog_d  = 1'b1;
        state_d = S_IDLE;
        clr     = 1'b1;
      end
      cnt_d = cnt_q + 32'd1;
`endif
    end

    // a command executing now overrides core events of the same cycle
    if (exec) begin
      err_d = 1'b1;
      unique case (ex_op)
        OP_OPEN: if (state_q == S_IDLE) begin
          state_d = S_LOAD;
          err_d   = 1'b0;
`ifdef BRIDGE_WDOG_EN
          wdog_d  = 1'b0;
`endif
        end
        OP_WRITE: if (state_q == S_LOAD && in_ok && ch_ok) begin
          for (int i = 0; i < N_IN; i++) begin
            if (int'(reg_idx) == i) ops_d[i] = (ops_q[i] & ~wmask) | wbits;
          end
          err_d = 1'b0;
        end
        OP_START: if (state_q == S_LOAD) begin
          state_d = S_RUN;
          err_d   = 1'b0;
`ifdef BRIDGE_WDOG_EN
          cnt_d   = '0;
`endif
        end
        OP_READ: if (state_q == S_READ && out_ok && ch_ok) begin
          rdata_d = CHUNK_W'(PAD_W'(rsel) >> sh);
          err_d   = 1'b0;
        end
        OP_RELEASE: if (state_q == S_READ) begin
          state_d = S_IDLE;
          clr     = 1'b1;
          err_d   = 1'b0;
        end
        OP_ABORT: begin
          state_d = S_IDLE;
          clr     = 1'b1;
          err_d   = 1'b0;
        end
        default: err_d = 1'b1;
      endcase
    end

    if (clr) begin
      for (int i = 0; i < N_IN; i++) ops_d[i] = '0;
      for (int i = 0; i < N_OUT; i++) res_d[i] = '0;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < N_IN; i++) ops_q[i] <= '0;
      for (int i = 0; i < N_OUT; i++) res_q[i] <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      res_q   <= res_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef BRIDGE_WDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wdog_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wdog_q <= wdog_d;
    end
  end

  assign sts_wdog = wdog_q;
`else
  assign sts_wdog = 1'b0;
`endif

  assign sts_state = state_q;
  assign sts_err   = err_q;
  assign rdata     = rdata_q;
  assign core_en   = (state_q == S_RUN);
  assign core_ki   = ops_q[KEY_IDX][0];

endmodule
